// File: rtl/ch_gather_pkg.sv
// Shared channel constants and helpers for the serializer/gather pair.
// Channel tags are one-hot; counts outside 1..CH_MAX mean "all channels".
package ch_pkg;

  localparam int CH_W   = 16;
  localparam int CH_MAX = 8;

  function automatic logic [3:0] clamp_numch(input logic [3:0] numch);
    if (numch == 4'd0 || numch > 4'(CH_MAX))
      return 4'(CH_MAX);
    return numch;
  endfunction

  function automatic logic [CH_MAX-1:0] onehot(input logic [2:0] idx);
    return CH_MAX'(1) << idx;
  endfunction

endpackage

// File: rtl/ch_gather_if.sv
// Serialized sample bus in, parallel frame out.
// The master drives samples; the gather block is the slave.
interface ch_gather_if #(
  parameter int W   = ch_pkg::CH_W,
  parameter int NCH = ch_pkg::CH_MAX
) ();

  logic             strobe;
  logic [3:0]       numch;
  logic [NCH-1:0]   ch_in;
  logic [W-1:0]     d_in;
  logic [NCH*W-1:0] d_out;
  logic             valid;
  logic             sync_err;
  logic [2:0]       ch_idx;

  modport master (
    output strobe, numch, ch_in, d_in,
    input  d_out, valid, sync_err, ch_idx
  );

  modport slave (
    input  strobe, numch, ch_in, d_in,
    output d_out, valid, sync_err, ch_idx
  );

endinterface

// File: rtl/ch_gather_seq.sv
// Channel sequencer: expected index, latched frame length, tag compare.
// A channel-0 tag always starts a frame, whether expected or a resync.
module ch_gather_seq
  import ch_pkg::*;
#(
  parameter int NCH = CH_MAX
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           strobe,
  input  logic [3:0]     numch,
  input  logic [NCH-1:0] ch_in,
  output logic           accept,
  output logic           last,
  output logic           resync,
  output logic           err,
  output logic [2:0]     idx,
  output logic [2:0]     pos,
  output logic [3:0]     n_eff
);

  logic [3:0] n_lat;
  logic [3:0] n_lat_d;
  logic [2:0] idx_d;
  logic       match;
  logic       start;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      n_lat <= 4'(NCH);
    end else begin
      idx   <= idx_d;
      n_lat <= n_lat_d;
    end
  end

  always_comb begin
    match   = (ch_in == onehot(idx));
    start   = strobe && (ch_in == onehot(3'd0));
    accept  = strobe && match;
    resync  = start && (idx != 3'd0);
    err     = strobe && !match;
    n_eff   = start ? clamp_numch(numch) : n_lat;
    pos     = start ? 3'd0 : idx;
    last    = (accept || resync)
           && ({1'b0, pos} == n_eff - 4'd1);
    n_lat_d = start ? n_eff : n_lat;
    idx_d   = idx;
    if (last)
      idx_d = 3'd0;
    else if (accept || resync)
      idx_d = pos + 3'd1;
    else if (err)
      idx_d = 3'd0;
  end

endmodule

// File: rtl/ch_gather.sv
// Reassembles one-hot tagged serial samples into a parallel frame.
// Completed frames land in d_out atomically with a one-cycle valid.
module ch_gather
  import ch_pkg::*;
#(
  parameter int W   = CH_W,
  parameter int NCH = CH_MAX
) (
  input logic         clk,
  input logic         rst,
  ch_gather_if.slave  bus
);

  logic [W-1:0]     shadow [NCH];
  logic [NCH*W-1:0] frame;
  logic             accept;
  logic             last;
  logic             resync;
  logic             err;
  logic [2:0]       idx;
  logic [2:0]       pos;
  logic [3:0]       n_eff;

  ch_gather_seq #(.NCH(NCH)) u_seq (
    .clk    (clk),
    .rst    (rst),
    .strobe (bus.strobe),
    .numch  (bus.numch),
    .ch_in  (bus.ch_in),
    .accept (accept),
    .last   (last),
    .resync (resync),
    .err    (err),
    .idx    (idx),
    .pos    (pos),
    .n_eff  (n_eff)
  );

  assign bus.ch_idx = idx;

  // Current sample merged in; lanes past the frame length read as zero.
  always_comb begin
    frame = '0;
    for (int k = 0; k < NCH; k++) begin
      if (k < int'(n_eff))
        frame[k*W +: W] = (k == int'(pos)) ? bus.d_in : shadow[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++)
        shadow[k] <= '0;
      bus.d_out    <= '0;
      bus.valid    <= 1'b0;
      bus.sync_err <= 1'b0;
    end else begin
      bus.valid    <= last;
      bus.sync_err <= err;
      if (accept || resync)
        shadow[pos] <= bus.d_in;
      if (last)
        bus.d_out <= frame;
    end
  end

endmodule

// File: tb/tb_ch_gather.sv
// Directed bench for ch_gather with a queue-based frame model.
// Each cycle's outputs are compared against the model, plus literal pins.
module tb_ch_gather;

  logic clk = 1'b0;
  logic rst;

  int checks   = 0;
  int failures = 0;

  ch_gather_if #(.W(16), .NCH(8)) bus ();

  ch_gather dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic [15:0]  part [$];
  int           n_m;
  logic [127:0] exp_dout;
  logic         exp_valid;
  logic         exp_err;
  logic [2:0]   exp_idx;
  int           vcount;

  task automatic chk(input string name, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic int clampn(input logic [3:0] v);
    return (v == 0 || v > 8) ? 8 : int'(v);
  endfunction

  // Frame = consecutive tags 1<<0, 1<<1, ... up to the length latched
  // by the channel-0 sample that opened it.
  task automatic model(input logic r, input logic s,
                       input logic [7:0] t, input logic [15:0] d);
    logic [7:0] want;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (r) begin
      part.delete();
      n_m      = 8;
      exp_dout = '0;
    end else if (s) begin
      want = 8'd1 << part.size();
      if (t == want) begin
        if (part.size() == 0)
          n_m = clampn(bus.numch);
        part.push_back(d);
      end else if (t == 8'd1) begin
        exp_err = 1'b1;
        part.delete();
        part.push_back(d);
        n_m = clampn(bus.numch);
      end else begin
        exp_err = 1'b1;
        part.delete();
      end
      if (part.size() != 0 && part.size() == n_m) begin
        exp_valid = 1'b1;
        exp_dout  = '0;
        for (int i = 0; i < n_m; i++)
          exp_dout[i*16 +: 16] = part[i];
        part.delete();
      end
    end
    exp_idx = 3'(part.size());
  endtask

  task automatic compare();
    chk("d_out",    bus.d_out,    exp_dout);
    chk("valid",    bus.valid,    exp_valid);
    chk("sync_err", bus.sync_err, exp_err);
    chk("ch_idx",   bus.ch_idx,   exp_idx);
    vcount += int'(bus.valid);
  endtask

  task automatic cyc(input logic r, input logic s,
                     input logic [7:0] t, input logic [15:0] d);
    rst        = r;
    bus.strobe = s;
    bus.ch_in  = t;
    bus.d_in   = d;
    model(r, s, t, d);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 8'h00, 16'h0000);
  endtask

  task automatic str(input logic [7:0] t, input logic [15:0] d);
    cyc(1'b0, 1'b1, t, d);
  endtask

  initial begin
    vcount     = 0;
    bus.numch  = 4'd4;
    rst        = 1'b1;
    bus.strobe = 1'b0;
    bus.ch_in  = '0;
    bus.d_in   = '0;
    cyc(1'b1, 1'b0, 8'h00, 16'h0);
    cyc(1'b1, 1'b0, 8'h00, 16'h0);
    chk("rst_dout", bus.d_out, 128'h0);
    idle();

    // Nominal 4-channel frame
    bus.numch = 4'd4;
    str(8'h01, 16'h1111);
    str(8'h02, 16'h2222);
    str(8'h04, 16'h3333);
    chk("nom_pre", bus.valid, 1'b0);
    str(8'h08, 16'h4444);
    chk("nom_valid", bus.valid, 1'b1);
    chk("nom_lo", bus.d_out[63:0], 64'h4444_3333_2222_1111);
    chk("nom_hi", bus.d_out[127:64], 64'h0);
    idle();

    // Gapped 8-channel frame
    bus.numch = 4'd8;
    vcount    = 0;
    for (int i = 0; i < 8; i++) begin
      str(8'(1 << i), 16'(8'hA0 + i));
      if (i == 7)
        chk("gap_top", bus.d_out[127:112], 16'h00A7);
      idle();
      idle();
    end
    chk("gap_nvalid", vcount, 1);

    // Resync on channel 0
    bus.numch = 4'd3;
    str(8'h01, 16'd1);
    str(8'h02, 16'd2);
    str(8'h01, 16'd3);
    chk("rs_err", bus.sync_err, 1'b1);
    chk("rs_novalid", bus.valid, 1'b0);
    str(8'h02, 16'd4);
    str(8'h04, 16'd5);
    chk("rs_valid", bus.valid, 1'b1);
    chk("rs_dout", bus.d_out, 128'h0005_0004_0003);
    idle();

    // Bad tag drops sample, zero tag also flagged
    bus.numch = 4'd4;
    str(8'h01, 16'hBEEF);
    str(8'h08, 16'hDEAD);
    chk("bad_err", bus.sync_err, 1'b1);
    chk("bad_idx", bus.ch_idx, 3'd0);
    str(8'h00, 16'h1234);
    chk("zero_err", bus.sync_err, 1'b1);
    str(8'h03, 16'h1234);
    idle();

    // numch=0 and numch=12 both behave as 8
    bus.numch = 4'd0;
    for (int i = 0; i < 8; i++)
      str(8'(1 << i), 16'(16'h0C00 + i));
    chk("clamp0_valid", bus.valid, 1'b1);
    bus.numch = 4'd12;
    for (int i = 0; i < 8; i++)
      str(8'(1 << i), 16'(16'h0D00 + i));
    chk("clamp12_top", bus.d_out[127:112], 16'h0D07);

    // numch=1: every channel-0 sample is a frame
    bus.numch = 4'd1;
    vcount    = 0;
    str(8'h01, 16'h0055);
    str(8'h01, 16'h0056);
    str(8'h01, 16'h0057);
    chk("n1_valids", vcount, 3);
    chk("n1_dout", bus.d_out, 128'h57);

    // numch change mid-frame only affects the next frame
    bus.numch = 4'd2;
    str(8'h01, 16'h0010);
    bus.numch = 4'd4;
    str(8'h02, 16'h0020);
    chk("chg_dout", bus.d_out, 128'h0020_0010);
    str(8'h01, 16'h0030);
    str(8'h02, 16'h0040);
    chk("chg_novalid", bus.valid, 1'b0);
    str(8'h04, 16'h0050);
    str(8'h08, 16'h0060);
    chk("chg_dout4", bus.d_out, 128'h0060_0050_0040_0030);

    // Reset mid-frame
    str(8'h01, 16'h0AAA);
    str(8'h02, 16'h0BBB);
    cyc(1'b1, 1'b0, 8'h00, 16'h0);
    chk("mrst_dout", bus.d_out, 128'h0);
    chk("mrst_idx", bus.ch_idx, 3'd0);
    str(8'h01, 16'h0001);
    str(8'h02, 16'h0002);
    str(8'h04, 16'h0003);
    str(8'h08, 16'h0004);
    chk("mrst_frame", bus.d_out, 128'h0004_0003_0002_0001);
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ch_gather.md
# ch_gather

Receive-side counterpart of the channel serializer. It accepts a time-multiplexed stream of 16-bit samples, each tagged with a one-hot channel code, and reassembles them into a parallel frame of up to 8 channels. Each completed frame is presented atomically with a one-cycle valid pulse. It sits between the serialized sample bus and wide per-channel consumers (decimators, packers), and checks channel sequencing and resynchronizes when the sequence is broken.

## Interface
- `W`, 16, sample width in bits
- `NCH`, 8, maximum channel count; sets the one-hot tag width and frame width `NCH*W`

- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `strobe`  in  1  sample valid; one sample accepted per cycle in which it is high
- `numch`  in  4  active channel count; 0 or values above `NCH` are treated as `NCH`
- `ch_in`  in  NCH  one-hot tag of the current sample (bit k = channel k)
- `d_in`  in  W  current sample
- `d_out`  out  NCH*W  last complete frame; channel k in bits `[k*W +: W]`
- `valid`  out  1  one-cycle pulse; `d_out` updated this cycle
- `sync_err`  out  1  one-cycle pulse; sequencing violation detected
- `ch_idx`  out  3  next expected channel index

## Operation
- **State.**
  - `idx` (0..NCH-1): expected channel.
  - `n_lat`: active count, clamped; latched when a channel-0 sample is accepted.
  - `shadow`: NCH×W accumulation register.
- **Accept (strobe=1, `ch_in == 1<<idx`).**
  - Write `d_in` into `shadow[idx]`.
  - If `idx == n_lat-1`: copy `shadow`, with the current sample merged in, into `d_out`. Lanes at or above `n_lat` are forced to 0. Assert `valid`. Set `idx` to 0.
  - Otherwise: increment `idx`.
- **numch changes.** Changes only take effect at the next accepted channel-0 sample. A mid-frame change does not alter the frame in progress.
- **Mismatch (strobe=1, tag is not `1<<idx`).** Assert `sync_err` and discard the partial frame; `valid` is not asserted.
  - If `ch_in == 1` (channel 0): resync. Treat the sample as a normal channel-0 accept: store it in `shadow[0]`, latch `n_lat`, set `idx` to 1. If `n_lat == 1`, complete the frame immediately.
  - Otherwise: drop the sample and set `idx` to 0.
- **Tag validity.** A tag that is not one-hot, including all-zeros, counts as a mismatch.
- **strobe=0.** No state change; `valid` and `sync_err` are low.
- **numch=1.** Every accepted channel-0 sample produces a frame. Bits above W are 0.
- **Wrap-around.** After the last channel, `idx` returns to 0 with no gap cycle. Back-to-back frames are supported at one sample per clock.

## Timing
- **Reset values.** `d_out`=0, `valid`=0, `sync_err`=0, `ch_idx`=0; `shadow`=0; `n_lat`=NCH.
- **rst mid-frame.** Discards the partial frame. The first strobe after reset must carry channel 0.
- **Latency.** Last-channel strobe at cycle N → `d_out` and `valid` registered and visible at N+1. `sync_err` is also visible at N+1.
- **Frame hold.** `d_out` holds between `valid` pulses. It never changes except on a `valid` cycle.
- **ch_idx.** Registered; reflects `idx` after the last update.
- **Throughput.** 1 sample/cycle. No backpressure; a downstream block must capture `d_out` before the next `valid`.

## Structure
- **Package `ch_pkg`.**
  - `CH_W=16` and `CH_MAX=8`.
  - Function `clamp_numch(numch)`: 0 or >8 → 8.
  - Function `onehot(idx)`.
  - Shared with the serializer.
- **Sub-module `ch_gather_seq`.** Holds `idx` and `n_lat`, performs the tag compare, and produces `accept`, `last`, `resync`, `err`. The top level holds `shadow`, `d_out` and the output registers.

## Test plan
- **Nominal frame.** numch=4, strobe every cycle, tags 01,02,04,08, data 0x1111..0x4444 → one `valid` at last+1; `d_out[63:0]`=0x4444_3333_2222_1111, upper 64 bits 0, `sync_err` 0.
- **Gapped strobes.** numch=8, tags 01..80 with data 0xA0..0xA7, idle cycles between strobes → a single `valid`; `d_out[127:112]`=0x00A7; `d_out` unchanged between frames.
- **Resync on channel 0.** numch=3, tags 01,02,01,02,04 with data 1,2,3,4,5 → `sync_err` pulse after the third strobe; `valid` only after the fifth; `d_out[47:0]`=0x0005_0004_0003.
- **Bad tag and drop.** Tags 01 then 08 with numch=4 → `sync_err`, sample dropped, `ch_idx`=0; tag 00 with strobe → also `sync_err`.
- **Clamp and numch change.** numch=0 behaves as 8. numch=1: three strobes tagged 01 give three `valid` pulses. numch changed 2→4 mid-frame: the current frame completes at 2 channels; the next frame needs 4.
- **Reset mid-frame.** rst after two of four samples → all outputs 0 the next cycle; a new full frame then completes normally.
